// File: rtl/snoop_bus_if.sv
// Shared snooping-bus signal bundle between the L1 requesters/snoopers,
// the bus arbiter and the L2/memory port.
interface snoop_bus_if #(
  parameter int NUM_CORES = 4,
  parameter int LADDR_W   = 26,
  parameter int LINE_W    = 512
);
  // Requester side
  logic [NUM_CORES-1:0]         req_valid;
  logic [NUM_CORES*LADDR_W-1:0] req_addr;
  logic [NUM_CORES*2-1:0]       req_type;
  logic [NUM_CORES*LINE_W-1:0]  req_wdata;
  logic [NUM_CORES-1:0]         done;
  logic [LINE_W-1:0]            resp_data;
  logic                         resp_shared;

  // Snoop broadcast and responses
  logic                         snoop_valid;
  logic [LADDR_W-1:0]           snoop_addr;
  logic [1:0]                   snoop_req;
  logic [NUM_CORES-1:0]         snoop_mask;
  logic [NUM_CORES-1:0]         snoop_shared;
  logic [NUM_CORES*LINE_W-1:0]  snoop_data;

  // L2/memory port
  logic                         mem_valid;
  logic                         mem_ready;
  logic                         mem_we;
  logic [LADDR_W-1:0]           mem_addr;
  logic [LINE_W-1:0]            mem_wdata;
  logic                         mem_rvalid;
  logic [LINE_W-1:0]            mem_rdata;

  // Arbiter view
  modport master (
    input  req_valid, req_addr, req_type, req_wdata,
    input  snoop_shared, snoop_data,
    input  mem_ready, mem_rvalid, mem_rdata,
    output done, resp_data, resp_shared,
    output snoop_valid, snoop_addr, snoop_req, snoop_mask,
    output mem_valid, mem_we, mem_addr, mem_wdata
  );

  // Cache/memory view
  modport slave (
    output req_valid, req_addr, req_type, req_wdata,
    output snoop_shared, snoop_data,
    output mem_ready, mem_rvalid, mem_rdata,
    input  done, resp_data, resp_shared,
    input  snoop_valid, snoop_addr, snoop_req, snoop_mask,
    input  mem_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/snoop_bus_arbiter.sv
// Snooping-bus arbiter: round-robin grant of one L1 request at a time,
// snoop broadcast, peer-data forwarding or memory sequencing, and a
// one-cycle completion pulse back to the granted core.
module snoop_bus_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int LADDR_W   = 26,
  parameter int LINE_W    = 512
) (
  input  logic        clk,
  input  logic        reset_n,
  snoop_bus_if.master bus
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  typedef enum logic [1:0] {
    BUS_RD   = 2'd0,
    BUS_RDX  = 2'd1,
    BUS_UPGR = 2'd2,
    BUS_WB   = 2'd3
  } bus_req_t;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SNOOP    = 3'd1,
    COLLECT  = 3'd2,
    MEM_REQ  = 3'd3,
    MEM_WAIT = 3'd4,
    RESP     = 3'd5
  } state_t;

  // First set bit at or after base, wrapping; base itself if none is set.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORES-1:0] reqs,
                                                input logic [IDX_W-1:0]     base);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] sel;
    int               idx;
    pick = base;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      idx = int'(base) + i;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      sel = IDX_W'(idx);
      if (reqs[sel]) pick = sel;
    end
    return pick;
  endfunction

  // Index of the lowest set bit; 0 if none is set.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_CORES-1:0] v);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] sel;
    pick = '0;
    for (int i = NUM_CORES - 1; i >= 0; i--) begin
      sel = IDX_W'(i);
      if (v[sel]) pick = sel;
    end
    return pick;
  endfunction

  state_t                  state_q;
  state_t                  state_d;
  logic [IDX_W-1:0]        rr_ptr;
  logic                    grant_en;
  logic [IDX_W-1:0]        grant_idx;

  // Transaction registers, captured at grant and held for the whole transaction
  logic [IDX_W-1:0]        owner_p0;
  logic [LADDR_W-1:0]      addr_p0;
  bus_req_t                type_p0;
  logic [LINE_W-1:0]       wdata_p0;

  logic [NUM_CORES-1:0]    owner_oh;
  logic [NUM_CORES-1:0]    sharers;
  logic [IDX_W-1:0]        sharer_idx;
  logic                    txn_is_wb;

  assign grant_idx  = rr_pick(bus.req_valid, rr_ptr);
  assign owner_oh   = NUM_CORES'(1) << owner_p0;
  // The owner's own snooper never supplies data to itself.
  assign sharers    = bus.snoop_shared & ~owner_oh;
  assign sharer_idx = lowest_set(sharers);
  assign txn_is_wb  = (type_p0 == BUS_WB);

  // FSM state register; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and the outputs decoded from state and transaction registers.
  always_comb begin
    state_d         = state_q;
    grant_en        = 1'b0;
    bus.done        = '0;
    bus.snoop_valid = 1'b0;
    bus.snoop_addr  = '0;
    bus.snoop_req   = '0;
    bus.snoop_mask  = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_we      = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_wdata   = '0;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant_en = 1'b1;
          state_d  = SNOOP;
        end
      end
      SNOOP: begin
        bus.snoop_valid = 1'b1;
        bus.snoop_addr  = addr_p0;
        bus.snoop_req   = type_p0;
        bus.snoop_mask  = owner_oh;
        state_d         = COLLECT;
      end
      COLLECT: begin
        if (type_p0 == BUS_UPGR) begin
          state_d = RESP;
        end else if (txn_is_wb) begin
          state_d = MEM_REQ;
        end else if (|sharers) begin
          state_d = RESP;
        end else begin
          state_d = MEM_REQ;
        end
      end
      MEM_REQ: begin
        bus.mem_valid = 1'b1;
        bus.mem_we    = txn_is_wb;
        bus.mem_addr  = addr_p0;
        bus.mem_wdata = wdata_p0;
        if (bus.mem_ready) begin
          state_d = txn_is_wb ? RESP : MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (bus.mem_rvalid) begin
          state_d = RESP;
        end
      end
      RESP: begin
        bus.done = owner_oh;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Round-robin pointer advances past the owner when its transaction completes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr <= '0;
    end else if (state_q == RESP) begin
      rr_ptr <= (owner_p0 == IDX_W'(NUM_CORES - 1)) ? '0 : owner_p0 + IDX_W'(1);
    end
  end

  // Stage p0: latch the granted request; later req_* changes are ignored.
  always_ff @(posedge clk) begin
    if (grant_en) begin
      owner_p0 <= grant_idx;
      addr_p0  <= bus.req_addr[grant_idx*LADDR_W +: LADDR_W];
      type_p0  <= bus_req_t'(bus.req_type[grant_idx*2 +: 2]);
      wdata_p0 <= bus.req_wdata[grant_idx*LINE_W +: LINE_W];
    end
  end

  // Response line and shared flag; held until a later transaction rewrites them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.resp_data   <= '0;
      bus.resp_shared <= 1'b0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (type_p0 == BUS_UPGR) begin
            bus.resp_data   <= '0;
            bus.resp_shared <= 1'b0;
          end else if (!txn_is_wb && (|sharers)) begin
            bus.resp_data   <= bus.snoop_data[sharer_idx*LINE_W +: LINE_W];
            bus.resp_shared <= 1'b1;
          end
        end
        MEM_WAIT: begin
          if (bus.mem_rvalid) begin
            bus.resp_data   <= bus.mem_rdata;
            bus.resp_shared <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/snoop_bus_arbiter.md
Name: snoop_bus_arbiter

Overview:
- Central controller for the shared snooping bus between NUM_CORES private L1 caches and the L2/memory port.
- Grants the bus round-robin to one L1 requester at a time and broadcasts the transaction to every L1 snooper.
- Collects the snooper responses one cycle later, then either forwards cache-to-cache data or sequences a memory read/write.
- Returns a one-cycle completion pulse with the line data and shared status to the granted requester.

Parameters:
- NUM_CORES, 4: number of L1 requesters/snoopers; must be ≥2.
- LADDR_W, 26: line address width (ADDR_BITS − OFFSET_BITS).
- LINE_W, 512: cacheline width in bits.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_CORES  per-core request; held high until done
- req_addr  in  NUM_CORES*LADDR_W  per-core line address; slice i belongs to core i
- req_type  in  NUM_CORES*2  per-core bus_req_t: BUS_RD=0, BUS_RDX=1, BUS_UPGR=2, BUS_WB=3
- req_wdata  in  NUM_CORES*LINE_W  writeback line, used for BUS_WB
- done  out  NUM_CORES  one-hot completion pulse to the granted core
- resp_data  out  LINE_W  line returned with done
- resp_shared  out  1  line was supplied by a peer L1
- snoop_valid  out  1  broadcast strobe to all snoopers
- snoop_addr  out  LADDR_W  broadcast line address
- snoop_req  out  2  broadcast bus_req_t
- snoop_mask  out  NUM_CORES  one-hot owner; the snooper of the masked core gets valid gated off
- snoop_shared  in  NUM_CORES  per-snooper shared, valid one cycle after snoop_valid
- snoop_data  in  NUM_CORES*LINE_W  per-snooper data, valid with snoop_shared
- mem_valid  out  1  memory request
- mem_ready  in  1  memory accepts the request when it is high together with mem_valid
- mem_we  out  1  1 = write (BUS_WB), 0 = read
- mem_addr  out  LADDR_W  memory line address
- mem_wdata  out  LINE_W  write data
- mem_rvalid  in  1  read data return strobe
- mem_rdata  in  LINE_W  read data

Behaviour:
- Reset state:
  - FSM in IDLE; round-robin pointer = 0.
  - All outputs 0: done, resp_data, resp_shared, snoop_*, mem_*.
  - Reset mid-transaction abandons the transaction. No done is issued.
- FSM states: IDLE, SNOOP, COLLECT, MEM_REQ, MEM_WAIT, RESP.
- IDLE:
  - If any req_valid is high, grant the first requesting core at or after the pointer, wrapping modulo NUM_CORES.
  - Latch the granted core's index, address, type and wdata into the transaction registers, then go to SNOOP.
  - Later changes to req_* during the transaction are ignored.
- SNOOP (1 cycle):
  - snoop_valid=1; snoop_addr, snoop_req and snoop_mask are driven from the latched values.
  - Go to COLLECT.
- COLLECT (1 cycle):
  - Sample snoop_shared with the owner bit masked off.
  - BUS_UPGR: go to RESP with resp_data=0, resp_shared=0.
  - BUS_WB: go to MEM_REQ as a write; snoop responses are ignored.
  - BUS_RD / BUS_RDX with any sharer: resp_data = snoop_data of the lowest-index sharer, resp_shared=1; go to RESP. No memory access.
  - BUS_RD / BUS_RDX with no sharer: go to MEM_REQ as a read.
- MEM_REQ:
  - mem_valid=1 with mem_addr, mem_we and mem_wdata from the latched values.
  - Hold all memory outputs stable until mem_ready.
  - On acceptance: a write goes to RESP; a read goes to MEM_WAIT.
- MEM_WAIT:
  - On mem_rvalid: resp_data = mem_rdata, resp_shared=0; go to RESP.
  - No timeout.
- RESP (1 cycle):
  - done[owner]=1 with resp_data and resp_shared valid.
  - Pointer = (owner+1) mod NUM_CORES; go to IDLE.
  - resp_data and resp_shared hold their values until the next transaction updates them.
- Requester rule: deassert req_valid in the cycle after done. A still-high req_valid is treated as a new request.
- Latency, request seen in IDLE at cycle T:
  - Snoop strobe at T+1.
  - Peer-supplied read, UPGR: done at T+3.
  - Memory read with mem_ready already high: done at T+4+(cycles until mem_rvalid), where mem_rvalid at the earliest is in the cycle after acceptance.
  - WB with mem_ready high: done at T+4.
- The bus is idle for at least one cycle between transactions, so snooper RESPOND cycles never overlap a new snoop_valid.
- Simultaneous requests are resolved only by the pointer. Requests arriving mid-transaction wait; there is no preemption.
- Outputs are registered except mem_valid, mem_addr, mem_we, mem_wdata, snoop_*, and done, which may be decoded from the state and transaction registers.

Test Plan:
- Core1 BUS_RD addr 0x123, no sharers, mem_ready=1, mem_rvalid 2 cycles after acceptance with data 0xAA.. → snoop_valid once with snoop_mask=0010; mem_we=0, mem_addr=0x123; done=0010 with resp_data=0xAA.., resp_shared=0.
- Core0 BUS_RD; snoop_shared=1100 with data 0x33../0x44.. → no mem_valid; done=0001 at T+3; resp_data=0x33.. (core2, lowest index); resp_shared=1.
- All four cores request together and hold until their done → grants in order 0,1,2,3, each done exactly once; a re-raised core0 request is next served after core3.
- Core2 BUS_WB with wdata 0x55.., mem_ready low for 3 cycles → mem_valid, mem_we=1 and mem_wdata held stable for 4 cycles; done=0100 on the cycle after acceptance.
- Core3 BUS_UPGR while its own snoop_shared bit is forced 1 → owner bit ignored; no memory access; done=1000 with resp_shared=0.
- reset_n pulsed low during MEM_WAIT → all outputs 0 immediately; no done; the next request is granted from pointer 0.
